// File: rtl/car_draw_engine.sv
// car_draw_engine: sweeps a CAR_W x CAR_H box through a synchronous sprite
// ROM, or paints it in background colour, and emits one pixel per cycle to
// the VGA adapter. Completion is reported with a level handshake that stays
// up until the request that started the operation is withdrawn.
module car_draw_engine #(
    parameter int          CAR_W       = 8,
    parameter int          CAR_H       = 8,
    parameter int          ADDR_W      = 6,
    parameter logic [2:0]  BG_COLOUR   = 3'b010,
    parameter logic [2:0]  TRANSPARENT = 3'b000,
    parameter int          SCREEN_W    = 160,
    parameter int          SCREEN_H    = 120
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              draw_car,
    input  logic              clear,
    input  logic [7:0]        car_x,
    input  logic [6:0]        car_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_data,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              plot,
    output logic              done_car,
    output logic              done_clear
);

    localparam int PX_W = (CAR_W > 1) ? $clog2(CAR_W) : 1;
    localparam int PY_W = (CAR_H > 1) ? $clog2(CAR_H) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWEEP  = 3'd1,
        ST_FLUSH1 = 3'd2,
        ST_FLUSH2 = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_r;
    logic [PX_W-1:0] px_r;
    logic [PY_W-1:0] py_r;
    logic [7:0]      base_x_r;
    logic [6:0]      base_y_r;
    logic            mode_r;        // 1 = clear (background), 0 = car sprite
    logic            done_car_r;
    logic            done_clear_r;

    logic            s1_valid_r;
    logic [PX_W-1:0] s1_px_r;
    logic [PY_W-1:0] s1_py_r;

    logic [7:0]      vga_x_r;
    logic [6:0]      vga_y_r;
    logic [2:0]      vga_colour_r;
    logic            plot_r;

    logic            req_s;
    logic            busy_s;
    logic            abort_s;
    logic            last_px_s;
    logic            last_py_s;
    logic [8:0]      sum_x_s;
    logic [7:0]      sum_y_s;
    logic            on_screen_s;
    logic            opaque_s;

    // The request that owns the current operation; the other one is ignored
    assign req_s       = mode_r ? clear : draw_car;
    assign busy_s      = (state_r == ST_SWEEP) || (state_r == ST_FLUSH1) || (state_r == ST_FLUSH2);
    assign abort_s     = busy_s && !req_s;
    assign last_px_s   = (px_r == PX_W'(CAR_W - 1));
    assign last_py_s   = (py_r == PY_W'(CAR_H - 1));

    // Screen coordinates are formed one bit wider so clipping sees the carry
    assign sum_x_s     = {1'b0, base_x_r} + 9'(s1_px_r);
    assign sum_y_s     = {1'b0, base_y_r} + 8'(s1_py_r);
    assign on_screen_s = (sum_x_s < 9'(SCREEN_W)) && (sum_y_s < 8'(SCREEN_H));
    assign opaque_s    = mode_r || (rom_data != TRANSPARENT);

    // Row-major sprite address for the pixel currently being swept
    always_comb begin
        rom_addr = ADDR_W'(py_r) * ADDR_W'(CAR_W) + ADDR_W'(px_r);
    end

    // Control FSM: request acceptance, box sweep, pipeline drain, done handshake
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            px_r         <= '0;
            py_r         <= '0;
            base_x_r     <= 8'd0;
            base_y_r     <= 7'd0;
            mode_r       <= 1'b0;
            done_car_r   <= 1'b0;
            done_clear_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_car_r   <= 1'b0;
                    done_clear_r <= 1'b0;
                    px_r         <= '0;
                    py_r         <= '0;
                    if (clear) begin
                        base_x_r <= car_x;
                        base_y_r <= car_y;
                        mode_r   <= 1'b1;
                        state_r  <= ST_SWEEP;
                    end else if (draw_car) begin
                        base_x_r <= car_x;
                        base_y_r <= car_y;
                        mode_r   <= 1'b0;
                        state_r  <= ST_SWEEP;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SWEEP: begin
                    if (!req_s) begin
                        px_r    <= '0;
                        py_r    <= '0;
                        state_r <= ST_IDLE;
                    end else if (last_px_s) begin
                        px_r <= '0;
                        if (last_py_s) begin
                            py_r    <= '0;
                            state_r <= ST_FLUSH1;
                        end else begin
                            py_r    <= py_r + PY_W'(1);
                        end
                    end else begin
                        px_r <= px_r + PX_W'(1);
                    end
                end
                ST_FLUSH1: begin
                    state_r <= req_s ? ST_FLUSH2 : ST_IDLE;
                end
                ST_FLUSH2: begin
                    state_r <= req_s ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    if (!req_s) begin
                        done_car_r   <= 1'b0;
                        done_clear_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        done_car_r   <= !mode_r;
                        done_clear_r <= mode_r;
                    end
                end
                default: begin
                    done_car_r   <= 1'b0;
                    done_clear_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    // Two-stage pixel pipeline aligned with the one-cycle ROM read latency
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_r   <= 1'b0;
            s1_px_r      <= '0;
            s1_py_r      <= '0;
            vga_x_r      <= 8'd0;
            vga_y_r      <= 7'd0;
            vga_colour_r <= 3'b000;
            plot_r       <= 1'b0;
        end else begin
            s1_valid_r <= (state_r == ST_SWEEP) && req_s;
            s1_px_r    <= px_r;
            s1_py_r    <= py_r;
            if (abort_s) begin
                plot_r <= 1'b0;
            end else begin
                plot_r <= s1_valid_r && on_screen_s && opaque_s;
            end
            if (s1_valid_r && !abort_s) begin
                vga_x_r      <= sum_x_s[7:0];
                vga_y_r      <= sum_y_s[6:0];
                vga_colour_r <= mode_r ? BG_COLOUR : rom_data;
            end else begin
                vga_x_r      <= vga_x_r;
                vga_y_r      <= vga_y_r;
                vga_colour_r <= vga_colour_r;
            end
        end
    end

    assign vga_x      = vga_x_r;
    assign vga_y      = vga_y_r;
    assign vga_colour = vga_colour_r;
    assign plot       = plot_r;
    assign done_car   = done_car_r;
    assign done_clear = done_clear_r;

endmodule

// File: doc/car_draw_engine.md
Name: car_draw_engine

Overview:
Drawing datapath that responds to the race control FSM's `draw_car` and `clear` requests. It latches the car position and sweeps a CAR_W x CAR_H box through a synchronous sprite ROM, emitting one pixel per cycle to the VGA adapter. Clear requests paint the box in background colour instead of sprite data. On completion it returns `done_car` or `done_clear` using a level handshake that the FSM polls.

Parameters:
CAR_W, 8, sprite width in pixels
CAR_H, 8, sprite height in pixels
ADDR_W, 6, sprite ROM address width (must satisfy 2^ADDR_W >= CAR_W*CAR_H)
BG_COLOUR, 3'b010, colour written during clear
TRANSPARENT, 3'b000, sprite colour that is never plotted
SCREEN_W, 160, horizontal resolution
SCREEN_H, 120, vertical resolution

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clock and reset are the only clock/reset ports
draw_car  in  1  request level: draw sprite
clear  in  1  request level: erase box to BG_COLOUR
car_x  in  8  box top-left x, sampled at request acceptance
car_y  in  7  box top-left y, sampled at request acceptance
rom_addr  out  ADDR_W  sprite ROM address, combinational = py*CAR_W+px
rom_data  in  3  sprite ROM data, valid one cycle after rom_addr
vga_x  out  8  pixel x, registered
vga_y  out  7  pixel y, registered
vga_colour  out  3  pixel colour, registered
plot  out  1  pixel write enable, registered
done_car  out  1  draw complete, held until draw_car falls
done_clear  out  1  clear complete, held until clear falls

Behaviour:
- Reset (reset=0, async): state IDLE; px, py, base, mode, pipeline valids = 0; plot, vga_x, vga_y, vga_colour, done_car, done_clear = 0.
- States: IDLE, SWEEP, FLUSH1, FLUSH2, DONE.
- IDLE, clear=1 at edge: latch base=(car_x,car_y), mode=CLEAR, enter SWEEP with px=py=0.
- IDLE, draw_car=1 only: same as above, with mode=CAR.
- Both draw_car and clear high in IDLE: clear wins.
- SWEEP: one pixel address per cycle.
  - px increments; at CAR_W-1, px wraps to 0 and py increments.
  - After (CAR_W-1, CAR_H-1), go to FLUSH1.
  - SWEEP lasts exactly CAR_W*CAR_H cycles.
- Pipeline stage 1 (edge after address): capture px, py, valid.
- Pipeline stage 2 (next edge): register the pixel outputs.
  - vga_x = base_x+px; vga_y = base_y+py (computed 9/8 bits wide, truncated on output).
  - vga_colour = BG_COLOUR if mode=CLEAR, else rom_data.
  - plot = valid AND x<SCREEN_W AND y<SCREEN_H AND NOT(mode=CAR AND rom_data==TRANSPARENT).
- FLUSH1 and FLUSH2 drain the pipeline, then the FSM enters DONE.
- Latency: first plot is visible 2 cycles after entering SWEEP; last plot is visible in the cycle before DONE.
- DONE: assert done_car (mode=CAR) or done_clear (mode=CLEAR), never both.
  - Hold done while the latched request input stays high.
  - Request low at edge: go to IDLE and drop done.
  - A new request is accepted no earlier than the following edge.
- Abort: latched request falls during SWEEP/FLUSH → IDLE at next edge.
  - Pipeline valids are cleared, so plot=0 from that edge.
  - No done is issued.
- The other request input is ignored outside IDLE.
- car_x/car_y changes after acceptance have no effect on the current sweep.
- Async reset asserted mid-operation: immediate return to reset values; no partial done.

Test Plan:
- Reset release, then draw_car=1, car_x=10, car_y=20, ROM returns 3'b100 for all addresses → 64 plots at (10..17, 20..27), colour 3'b100, row-major order. First plot 2 cycles after SWEEP entry; done_car high 67 edges after request edge; done_clear stays 0.
- done_car high, then draw_car dropped → done_car=0 next cycle, state IDLE; re-raising draw_car starts a new sweep.
- clear=1 and draw_car=1 in same cycle, car_x=0, car_y=0 → 64 plots, colour 3'b010, done_clear=1, done_car=0.
- ROM returns 3'b000 at even addresses, 3'b111 at odd → exactly 32 plots, all at odd px. clear on the same box → 64 plots.
- car_x=156, car_y=116 → only px 0..3 and py 0..3 plotted (16 plots); done_car still asserted after the full 64-cycle sweep.
- draw_car dropped at sweep cycle 10 → plot=0 from the next edge, no done_car. Separately, reset pulsed low mid-sweep → all outputs 0 asynchronously.
